// File: rtl/fft_frame_sequencer.sv
// Multi-channel frame sequencer feeding the FFT core.
// After reset it configures the FFT once. It then counts new samples and, once
// enough exist, streams one FRAME_LEN frame per channel back to back. A 2-entry
// skid buffer absorbs the read latency and honours data tready backpressure.
module fft_frame_sequencer #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned HOP_LEN = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CFG_WIDTH = 16,
  parameter logic [CFG_WIDTH-1:0] CFG_WORD = 16'h0001,
  localparam int unsigned CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int unsigned ADDR_W = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  data_ready,
  input  logic                  enable,
  input  logic                  s_axis_config_tready,
  output logic                  s_axis_config_tvalid,
  output logic [CFG_WIDTH-1:0]  s_axis_config_tdata,
  output logic                  buf_rd_en,
  output logic [CH_W-1:0]       buf_rd_chan,
  output logic [ADDR_W-1:0]     buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  output logic                  s_axis_data_tvalid,
  input  logic                  s_axis_data_tready,
  output logic                  s_axis_data_tlast,
  output logic [CH_W-1:0]       frame_chan,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FRAME_THR = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  HOP_THR   = CNT_W'(HOP_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]   LAST_CHAN = CH_W'(N_CHANNELS - 1);

  typedef enum logic [1:0] {CONFIG, IDLE, READ, DRAIN} state_t;

  state_t state, state_next;

  // Sample counting
  logic             ready_prev;
  logic             sample_edge;
  logic [CNT_W-1:0] sample_cnt;
  logic             hop_mode;
  logic [CNT_W-1:0] threshold;
  logic             saturated;
  logic             start;

  // Configuration handshake
  logic cfg_valid;
  logic cfg_fire;

  // Read side
  logic [CH_W-1:0]   rd_chan;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_issue;
  logic              last_issue;
  logic              inflight;
  logic [CH_W-1:0]   inflight_chan;
  logic [ADDR_W-1:0] inflight_addr;

  // Skid buffer
  logic [DATA_WIDTH-1:0] skid_data [2];
  logic [CH_W-1:0]       skid_chan [2];
  logic [ADDR_W-1:0]     skid_addr [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            skid_cnt;
  logic [1:0]            occ_after_pop;
  logic                  push;
  logic                  pop;
  logic                  drain_done;

  assign sample_edge = data_ready & ~ready_prev;
  assign threshold   = hop_mode ? HOP_THR : FRAME_THR;
  assign saturated   = (sample_cnt >= threshold);
  assign start       = (state == IDLE) && enable && saturated;

  assign cfg_fire = cfg_valid & s_axis_config_tready;

  assign push          = inflight;
  assign pop           = (skid_cnt != 2'd0) && s_axis_data_tready;
  assign occ_after_pop = skid_cnt - {1'b0, pop};
  // Occupancy is judged after this cycle's pop so a full-rate stream needs no bubble.
  assign rd_issue      = (state == READ) && ((occ_after_pop + {1'b0, inflight}) < 2'd2);
  assign last_issue    = rd_issue && (rd_chan == LAST_CHAN) && (rd_addr == LAST_ADDR);
  assign drain_done    = (occ_after_pop == 2'd0) && !inflight;

  assign s_axis_config_tvalid = cfg_valid;
  assign s_axis_config_tdata  = CFG_WORD;

  assign buf_rd_en   = rd_issue;
  assign buf_rd_chan = rd_chan;
  assign buf_rd_addr = rd_addr;

  assign s_axis_data_tvalid = (skid_cnt != 2'd0);
  assign s_axis_data_tdata  = skid_data[rd_ptr];
  assign frame_chan         = skid_chan[rd_ptr];
  assign s_axis_data_tlast  = s_axis_data_tvalid && (skid_addr[rd_ptr] == LAST_ADDR);

  assign busy = (state == READ) || (state == DRAIN);

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= CONFIG;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      CONFIG: if (cfg_fire)   state_next = IDLE;
      IDLE:   if (start)      state_next = READ;
      READ:   if (last_issue) state_next = DRAIN;
      DRAIN:  if (drain_done) state_next = IDLE;
      default:                state_next = CONFIG;
    endcase
  end

  // Config valid rises the first clock after reset and drops after its handshake
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cfg_valid <= 1'b0;
    end else begin
      cfg_valid <= (state == CONFIG) && !cfg_fire;
    end
  end

  // Sample edge counter with saturation, overrun flag and hop threshold switch
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ready_prev <= 1'b1;
      sample_cnt <= '0;
      hop_mode   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      ready_prev <= data_ready;
      overrun    <= sample_edge && saturated && !start;
      if (start) begin
        sample_cnt <= sample_edge ? CNT_W'(1) : '0;
        hop_mode   <= 1'b1;
      end else if (sample_edge && !saturated) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

  // Read address generator and in-flight tag for the 1-cycle read latency
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_chan       <= '0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_chan <= '0;
      inflight_addr <= '0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) begin
        inflight_chan <= rd_chan;
        inflight_addr <= rd_addr;
        if (rd_addr == LAST_ADDR) begin
          rd_addr <= '0;
          rd_chan <= (rd_chan == LAST_CHAN) ? '0 : rd_chan + CH_W'(1);
        end else begin
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Skid FIFO: captures returning read data with its tag, pops on handshake
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned i = 0; i < 2; i++) begin
        skid_data[i] <= '0;
        skid_chan[i] <= '0;
        skid_addr[i] <= '0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (push) begin
        skid_data[wr_ptr] <= buf_rd_data;
        skid_chan[wr_ptr] <= inflight_chan;
        skid_addr[wr_ptr] <= inflight_addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  // Frame completion pulse, coincident with the return to IDLE
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && drain_done;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with N=2, FRAME_LEN=8, HOP_LEN=4.
module tb_fft_frame_sequencer;

  localparam int N  = 2;
  localparam int F  = 8;
  localparam int H  = 4;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [15:0] CFG = 16'h0A51;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          data_ready;
  logic          enable;
  logic          s_axis_config_tready;
  logic          s_axis_config_tvalid;
  logic [CW-1:0] s_axis_config_tdata;
  logic          buf_rd_en;
  logic          buf_rd_chan;
  logic [2:0]    buf_rd_addr;
  logic [DW-1:0] buf_rd_data = '0;
  logic [DW-1:0] s_axis_data_tdata;
  logic          s_axis_data_tvalid;
  logic          s_axis_data_tready;
  logic          s_axis_data_tlast;
  logic          frame_chan;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .N_CHANNELS(N),
    .FRAME_LEN(F),
    .HOP_LEN(H),
    .DATA_WIDTH(DW),
    .CFG_WIDTH(CW),
    .CFG_WORD(CFG)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .data_ready(data_ready),
    .enable(enable),
    .s_axis_config_tready(s_axis_config_tready),
    .s_axis_config_tvalid(s_axis_config_tvalid),
    .s_axis_config_tdata(s_axis_config_tdata),
    .buf_rd_en(buf_rd_en),
    .buf_rd_chan(buf_rd_chan),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .s_axis_data_tdata(s_axis_data_tdata),
    .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tready(s_axis_data_tready),
    .s_axis_data_tlast(s_axis_data_tlast),
    .frame_chan(frame_chan),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_tag = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ring-buffer model: synchronous read, content encodes frame tag, channel, index
  always @(posedge clk) begin
    if (buf_rd_en)
      buf_rd_data <= (32'(frame_tag) << 16) | (32'(buf_rd_chan) << 8) | 32'(buf_rd_addr);
  end

  // Observation records
  logic [31:0] q_data[$];
  int          q_chan[$];
  bit          q_last[$];
  int          q_cyc[$];
  int fd_count, fd_cyc, ovr_count, cfg_hs, stab_err, out_err, issued, accepted;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  logic        prev_chan;

  always @(negedge clk) begin
    if (reset_b) begin
      if (prev_stall && (!s_axis_data_tvalid || s_axis_data_tdata !== prev_data ||
                         s_axis_data_tlast !== prev_last || frame_chan !== prev_chan))
        stab_err++;
      prev_stall = s_axis_data_tvalid && !s_axis_data_tready;
      prev_data  = s_axis_data_tdata;
      prev_last  = s_axis_data_tlast;
      prev_chan  = frame_chan;
      if (s_axis_data_tvalid && s_axis_data_tready) begin
        q_data.push_back(s_axis_data_tdata);
        q_chan.push_back(int'(frame_chan));
        q_last.push_back(s_axis_data_tlast);
        q_cyc.push_back(cyc);
        accepted++;
      end
      if (buf_rd_en) issued++;
      if (issued - accepted > 2) out_err++;
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (overrun) ovr_count++;
      if (s_axis_config_tvalid && s_axis_config_tready) cfg_hs++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_pulse();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    step();
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_chan.delete();
    q_last.delete();
    q_cyc.delete();
    fd_count = 0; fd_cyc = 0; ovr_count = 0; cfg_hs = 0;
    stab_err = 0; out_err = 0; issued = 0; accepted = 0;
  endtask

  function automatic logic [31:0] exp_data(int tag, int k);
    return (32'(tag) << 16) | (32'(k / F) << 8) | 32'(k % F);
  endfunction

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({s_axis_config_tvalid, s_axis_data_tvalid, s_axis_data_tlast, buf_rd_en,
         busy, frame_done, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000000", {s_axis_config_tvalid, s_axis_data_tvalid,
               s_axis_data_tlast, buf_rd_en, busy, frame_done, overrun});
    end
    checks++;
    if (s_axis_data_tdata !== 32'h0 || buf_rd_addr !== 3'd0 || buf_rd_chan !== 1'b0 || frame_chan !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got tdata=%h addr=%0d chan=%0d fchan=%0d exp all 0",
               s_axis_data_tdata, buf_rd_addr, buf_rd_chan, frame_chan);
    end
  endtask

  task automatic test_config();
    int hi;
    hi = 0;
    clear_mon();
    reset_b = 1'b1;
    step();
    checks++;
    if (s_axis_config_tdata !== CFG) begin
      errors++;
      $display("FAIL cfg_tdata got %h exp %h", s_axis_config_tdata, CFG);
    end
    for (int i = 0; i < 5; i++) begin
      if (s_axis_config_tvalid === 1'b1) hi++;
      step();
    end
    s_axis_config_tready = 1'b1;
    if (s_axis_config_tvalid === 1'b1) hi++;
    step();
    s_axis_config_tready = 1'b0;
    checks++;
    if (hi != 6) begin
      errors++;
      $display("FAIL cfg_valid_cycles got %0d exp 6", hi);
    end
    checks++;
    if (s_axis_config_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_valid_drop got %b exp 0", s_axis_config_tvalid);
    end
    repeat (3) step();
    checks++;
    if (cfg_hs != 1) begin
      errors++;
      $display("FAIL cfg_handshakes got %0d exp 1", cfg_hs);
    end
  endtask

  task automatic test_frame();
    int c;
    frame_tag = 1;
    enable = 1'b1;
    s_axis_data_tready = 1'b1;
    data_ready = 1'b0;
    step();
    clear_mon();
    repeat (7) edge_pulse();
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL first_threshold_early got busy=%b exp 0", busy);
    end
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    c = cyc;
    step();
    checks++;
    if (busy !== 1'b1 || buf_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL frame_start got busy=%b rd_en=%b exp 1 1", busy, buf_rd_en);
    end
    for (int i = 0; i < 100 && fd_count == 0; i++) step();
    repeat (3) step();
    checks++;
    if (q_data.size() != 16) begin
      errors++;
      $display("FAIL frame_count got %0d exp 16", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 16; k++) begin
      checks++;
      if (q_data[k] !== exp_data(1, k) || q_chan[k] != k / F || q_last[k] != (k % F == F - 1)) begin
        errors++;
        $display("FAIL frame_sample[%0d] got %h ch%0d last%0d exp %h ch%0d last%0d", k, q_data[k],
                 q_chan[k], q_last[k], exp_data(1, k), k / F, (k % F == F - 1));
      end
    end
    checks++;
    if (q_cyc.size() == 0 || q_cyc[0] != c + 3) begin
      errors++;
      $display("FAIL first_valid_latency got %0d exp %0d", (q_cyc.size() == 0) ? -1 : q_cyc[0] - c, 3);
    end
    checks++;
    if (q_cyc.size() < 16 || q_cyc[15] != c + 2 + N * F) begin
      errors++;
      $display("FAIL last_handshake got %0d exp %0d", (q_cyc.size() < 16) ? -1 : q_cyc[15] - c, 2 + N * F);
    end
    checks++;
    if (fd_count != 1 || fd_cyc != c + 3 + N * F) begin
      errors++;
      $display("FAIL frame_done got count=%0d at %0d exp count=1 at %0d", fd_count, fd_cyc - c, 3 + N * F);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_backpressure();
    frame_tag = 2;
    clear_mon();
    repeat (3) edge_pulse();
    repeat (2) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hop_threshold_early got busy=%b exp 0", busy);
    end
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || buf_rd_en !== 1'b1 || buf_rd_addr !== 3'd0) begin
      errors++;
      $display("FAIL hop_start got busy=%b rd_en=%b addr=%0d exp 1 1 0", busy, buf_rd_en, buf_rd_addr);
    end
    for (int i = 0; i < 400 && fd_count == 0; i++) begin
      s_axis_data_tready = 1'($urandom_range(0, 1));
      step();
    end
    s_axis_data_tready = 1'b1;
    repeat (3) step();
    checks++;
    if (q_data.size() != 16) begin
      errors++;
      $display("FAIL bp_count got %0d exp 16", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 16; k++) begin
      checks++;
      if (q_data[k] !== exp_data(2, k) || q_chan[k] != k / F || q_last[k] != (k % F == F - 1)) begin
        errors++;
        $display("FAIL bp_sample[%0d] got %h ch%0d last%0d exp %h ch%0d last%0d", k, q_data[k],
                 q_chan[k], q_last[k], exp_data(2, k), k / F, (k % F == F - 1));
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL bp_stable_under_stall got %0d violations exp 0", stab_err);
    end
    checks++;
    if (out_err != 0) begin
      errors++;
      $display("FAIL bp_outstanding_limit got %0d violations exp 0", out_err);
    end
    checks++;
    if (fd_count != 1) begin
      errors++;
      $display("FAIL bp_frame_done got %0d exp 1", fd_count);
    end
  endtask

  task automatic test_overrun();
    frame_tag = 3;
    enable = 1'b0;
    clear_mon();
    repeat (4) edge_pulse();
    step();
    checks++;
    if (ovr_count != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_at_threshold got ovr=%0d busy=%b exp 0 0", ovr_count, busy);
    end
    repeat (3) edge_pulse();
    step();
    checks++;
    if (ovr_count != 3) begin
      errors++;
      $display("FAIL ovr_pulses got %0d exp 3", ovr_count);
    end
    enable = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_immediate_start got busy=%b exp 1", busy);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 50 && q_data.size() < 3; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 200 && fd_count == 0; i++) step();
    repeat (3) step();
    checks++;
    if (q_data.size() != 16) begin
      errors++;
      $display("FAIL drop_count got %0d exp 16", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 16; k++) begin
      checks++;
      if (q_data[k] !== exp_data(3, k) || q_chan[k] != k / F) begin
        errors++;
        $display("FAIL drop_sample[%0d] got %h ch%0d exp %h ch%0d", k, q_data[k], q_chan[k],
                 exp_data(3, k), k / F);
      end
    end
    checks++;
    if (busy !== 1'b0 || fd_count != 1) begin
      errors++;
      $display("FAIL drop_idle got busy=%b done=%0d exp 0 1", busy, fd_count);
    end
  endtask

  task automatic test_reset_mid();
    frame_tag = 4;
    clear_mon();
    enable = 1'b1;
    repeat (4) edge_pulse();
    for (int i = 0; i < 20 && q_data.size() < 2; i++) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before_reset got %b exp 1", busy);
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if ({s_axis_config_tvalid, s_axis_data_tvalid, s_axis_data_tlast, buf_rd_en,
         busy, frame_done, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_flags got %b exp 0000000", {s_axis_config_tvalid, s_axis_data_tvalid,
               s_axis_data_tlast, buf_rd_en, busy, frame_done, overrun});
    end
    checks++;
    if (s_axis_data_tdata !== 32'h0 || buf_rd_addr !== 3'd0 || buf_rd_chan !== 1'b0 || frame_chan !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values got tdata=%h addr=%0d chan=%0d fchan=%0d exp all 0",
               s_axis_data_tdata, buf_rd_addr, buf_rd_chan, frame_chan);
    end
    step();
    reset_b = 1'b1;
    step();
    checks++;
    if (s_axis_config_tvalid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reconfig got cfg_valid=%b busy=%b exp 1 0", s_axis_config_tvalid, busy);
    end
    s_axis_config_tready = 1'b1;
    step();
    s_axis_config_tready = 1'b0;
    repeat (4) edge_pulse();
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || s_axis_config_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_full_threshold got busy=%b cfg_valid=%b exp 0 0", busy, s_axis_config_tvalid);
    end
  endtask

  initial begin
    reset_b = 1'b0;
    data_ready = 1'b1;
    enable = 1'b0;
    s_axis_config_tready = 1'b0;
    s_axis_data_tready = 1'b1;
    clear_mon();
    test_reset();
    test_config();
    test_frame();
    test_backpressure();
    test_overrun();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Multi-channel frame sequencer that sits between the per-hydrophone sample ring buffer and the Xilinx FFT core. After reset it configures the FFT once through a full valid/ready handshake. It counts incoming samples and, once enough new samples exist, streams one FRAME_LEN frame per channel back-to-back into the FFT, honouring `s_axis_data_tready` backpressure through an internal 2-entry skid buffer. It replaces the single-channel, no-backpressure controller and its edge-counting helper.

## Interface
Parameters:
- N_CHANNELS, 4, channels per trigger; CH_W = max(1, clog2(N_CHANNELS))
- FRAME_LEN, 1024, samples per FFT frame; power of 2, ≥4; ADDR_W = clog2(FRAME_LEN)
- HOP_LEN, 256, new samples required between frames; 1..FRAME_LEN
- DATA_WIDTH, 32, sample word width
- CFG_WIDTH, 16, config word width
- CFG_WORD, 16'h0001, value driven on config tdata

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_b  in  1  async active-low reset
- data_ready  in  1  level from sample path; each rising edge is one new sample on all channels
- enable  in  1  permits frame starts
- s_axis_config_tready  in  1  FFT config ready
- s_axis_config_tvalid  out  1  config valid
- s_axis_config_tdata  out  CFG_WIDTH  constant CFG_WORD
- buf_rd_en  out  1  ring-buffer read strobe; synchronous read, 1-cycle latency
- buf_rd_chan  out  CH_W  channel being read
- buf_rd_addr  out  ADDR_W  sample index in frame, 0 = oldest
- buf_rd_data  in  DATA_WIDTH  read data, valid the cycle after buf_rd_en
- s_axis_data_tdata  out  DATA_WIDTH  sample to FFT
- s_axis_data_tvalid  out  1  sample valid
- s_axis_data_tready  in  1  FFT accepts sample
- s_axis_data_tlast  out  1  last sample of a channel frame
- frame_chan  out  CH_W  channel of current output sample
- busy  out  1  high in READ/DRAIN
- frame_done  out  1  one-cycle pulse after final channel's tlast handshake
- overrun  out  1  one-cycle pulse on sample edge while sample counter saturated

## Operation
- States: CONFIG, IDLE, READ, DRAIN.
- CONFIG: entered from reset; config tvalid high and held until tready sampled high; then IDLE.
- Sample counter: rising edge detect on data_ready (previous-value register resets to 1, so a level high at reset release does not count). Saturates at threshold; edge while saturated → overrun pulse, count unchanged. Threshold FRAME_LEN before first frame after reset, HOP_LEN thereafter.
- IDLE → READ when enable and counter == threshold; counter cleared that cycle, or set to 1 if an edge coincides. Edges keep counting in all states.
- READ: issue reads chan 0 addr 0..FRAME_LEN-1, then chan 1, … up to chan N_CHANNELS-1. buf_rd_en asserted only when skid occupancy + in-flight reads < 2. Address wraps to 0 with chan+1 at FRAME_LEN-1. After last read issued → DRAIN.
- Skid: 2-entry FIFO capturing buf_rd_data with its chan/addr tag. Head drives tdata/frame_chan; tvalid = not empty; tlast = head addr == FRAME_LEN-1. Pops on tvalid & tready.
- DRAIN → IDLE when skid empty and nothing in flight; frame_done pulses the cycle after the final handshake (same cycle as IDLE entry).
- enable dropping mid-frame does not truncate; the full N_CHANNELS set completes.
- tvalid never deasserts before handshake; tdata/tlast/frame_chan stable while tvalid & !tready.

## Timing
- Reset values: config tvalid 0, data tvalid/tlast 0, tdata 0, buf_rd_en 0, buf_rd_chan/addr 0, frame_chan 0, busy 0, frame_done 0, overrun 0; state CONFIG; counter 0.
- Config tvalid high first clk after reset release.
- Start condition seen cycle C: READ and buf_rd_en at C+1, first tvalid at C+3.
- tready held high: one sample/cycle, last handshake at C+2+N_CHANNELS·FRAME_LEN, frame_done next cycle.
- tready low: at most 2 samples buffered; reads stall, no data lost or duplicated.
- Reset asserted mid-frame: immediate return to reset values, reconfiguration required.

## Test plan
- Reset release, config tready low 5 cycles then high → tvalid held 6 cycles, single handshake, CFG_WORD on tdata, then IDLE.
- N=2, FRAME_LEN=8, HOP_LEN=4, tready=1: 8 data_ready edges with enable → 16 samples, addr 0..7 per channel, tlast on samples 8 and 16, frame_done one pulse; next frame after 4 more edges.
- Random tready (50%) during frame → exact in-order sequence of 16 tagged samples, tdata stable under stall, no read while skid full.
- Edges continue with enable low past threshold → overrun pulse per extra edge, count holds; enable high starts frame immediately.
- enable dropped after 3 samples → all channels still sent, then IDLE.
- reset_b low mid-READ → all outputs at reset values that cycle; CONFIG re-entered on release.
